hiscore_ram_arbiter: RTL and testbench



---
 rtl/hiscore_ram_arbiter.sv | 163 ++++++++++++++++
 tb/tb_hiscore_ram_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hiscore_ram_arbiter.sv
// Hands the shared work-RAM port to the hiscore engine once the CPU is paused and settled.
// Optional build macro HSARB_TIMEOUT_EN adds a bounded wait for the pause acknowledge.
module hiscore_ram_arbiter #(
    parameter int AW             = 12,
    parameter int DW             = 8,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          hs_req,
    input  logic [AW-1:0] hs_addr,
    input  logic [DW-1:0] hs_wdata,
    input  logic          hs_we,
    input  logic          hs_rd,
    output logic          hs_grant,
    output logic [DW-1:0] hs_rdata,
    output logic          hs_rvalid,
    output logic          hs_timeout,
    output logic          pause_req,
    input  logic          cpu_paused,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata
);

    typedef enum logic [2:0] {IDLE, PAUSING, SETTLE, GRANTED, RELEASE} state_t;

    // Shared down-counter: settle interval, then the two-cycle read drain in RELEASE.
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] SETTLE_LOAD  = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] RELEASE_LOAD = CW'(1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          start_ok;
    logic          tmo_fire;
    logic          wr_go, rd_go;
    logic          rd_p1, rd_p2;

`ifdef HSARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [TW-1:0] tmo_cnt;
    logic          retry_block;
    logic          timeout_q;

    assign tmo_fire   = (state == PAUSING) && hs_req && !cpu_paused &&
                        (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign start_ok   = hs_req && !retry_block;
    assign hs_timeout = timeout_q;

    // A timed-out engine must drop hs_req before another session may start.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt     <= '0;
            retry_block <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            tmo_cnt <= (state == PAUSING && !tmo_fire) ? tmo_cnt + 1'b1 : '0;
            if (tmo_fire)
                retry_block <= 1'b1;
            else if (!hs_req)
                retry_block <= 1'b0;
            if (tmo_fire)
                timeout_q <= 1'b1;
        end
    end
`else
    assign tmo_fire   = 1'b0;
    assign start_ok   = hs_req;
    assign hs_timeout = 1'b0;
`endif

    // NOTE: next-state and counter defaults come first so no path leaves them unassigned (no latch).
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE:
                if (start_ok) state_nxt = PAUSING;
            PAUSING:
                if (!hs_req) begin
                    state_nxt = RELEASE;
                    cnt_nxt   = RELEASE_LOAD;
                end else if (cpu_paused) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = SETTLE_LOAD;
                end else if (tmo_fire) begin
                    state_nxt = RELEASE;
                    cnt_nxt   = RELEASE_LOAD;
                end
            SETTLE:
                if (!hs_req) begin
                    state_nxt = RELEASE;
                    cnt_nxt   = RELEASE_LOAD;
                end else if (!cpu_paused) begin
                    state_nxt = PAUSING;
                end else if (cnt == '0) begin
                    state_nxt = GRANTED;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            GRANTED:
                if (!hs_req) begin
                    state_nxt = RELEASE;
                    cnt_nxt   = RELEASE_LOAD;
                end else if (!cpu_paused) begin
                    state_nxt = PAUSING;
                end
            RELEASE:
                if (cnt == '0) state_nxt = IDLE;
                else           cnt_nxt   = cnt - 1'b1;
            default:
                state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            hs_grant  <= 1'b0;
            pause_req <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            hs_grant  <= (state_nxt == GRANTED);
            pause_req <= (state_nxt != IDLE);
        end
    end

    // Only granted accesses reach the RAM; a simultaneous write suppresses the read.
    assign wr_go = hs_grant && hs_we;
    assign rd_go = hs_grant && hs_rd && !hs_we;

    // The read pipeline is not gated by grant, so reads already issued still return.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            rd_p1     <= 1'b0;
            rd_p2     <= 1'b0;
            hs_rvalid <= 1'b0;
            hs_rdata  <= '0;
        end else begin
            ram_we <= wr_go;
            if (wr_go || rd_go)
                ram_addr <= hs_addr;
            if (wr_go)
                ram_wdata <= hs_wdata;
            rd_p1     <= rd_go;
            rd_p2     <= rd_p1;
            hs_rvalid <= rd_p2;
            if (rd_p2)
                hs_rdata <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// Directed bench for hiscore_ram_arbiter: scoreboards RAM writes and read returns with cycle stamps.
// The timeout scenario runs only when HSARB_TIMEOUT_EN is defined.
module tb_hiscore_ram_arbiter;

    localparam int AW = 12;
    localparam int DW = 8;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic          hs_req = 1'b0;
    logic [AW-1:0] hs_addr = '0;
    logic [DW-1:0] hs_wdata = '0;
    logic          hs_we = 1'b0;
    logic          hs_rd = 1'b0;
    logic          cpu_paused = 1'b0;
    logic          hs_grant, hs_rvalid, hs_timeout, pause_req, ram_we;
    logic [DW-1:0] hs_rdata, ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic [AW-1:0] ram_addr;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t wq[$];
    exp_t rq[$];

    hiscore_ram_arbiter #(
        .AW(AW), .DW(DW), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .hs_req(hs_req), .hs_addr(hs_addr), .hs_wdata(hs_wdata),
        .hs_we(hs_we), .hs_rd(hs_rd),
        .hs_grant(hs_grant), .hs_rdata(hs_rdata), .hs_rvalid(hs_rvalid),
        .hs_timeout(hs_timeout), .pause_req(pause_req), .cpu_paused(cpu_paused),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Synchronous RAM model: returns the low address byte one cycle after the address.
    always @(posedge clk_sys) ram_rdata <= ram_addr[7:0];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic push_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.cyc  = cyc + 1;
        wq.push_back(e);
    endtask

    task automatic push_read(input logic [AW-1:0] a);
        exp_t e;
        e.addr = a;
        e.data = a[7:0];
        e.cyc  = cyc + 3;
        rq.push_back(e);
    endtask

    // Output monitor, sampled mid-cycle away from the active edge.
    always @(negedge clk_sys) begin
        if (reset_n) begin
            if (ram_we) begin
                if (wq.size() == 0) begin
                    check("ram_we_unexpected", {31'd0, ram_we}, 32'd0);
                end else begin
                    exp_t e;
                    e = wq.pop_front();
                    check("ram_we_addr", {20'd0, ram_addr}, {20'd0, e.addr});
                    check("ram_we_data", {24'd0, ram_wdata}, {24'd0, e.data});
                    check("ram_we_cycle", cyc, e.cyc);
                end
            end
            if (hs_rvalid) begin
                if (rq.size() == 0) begin
                    check("rvalid_unexpected", {31'd0, hs_rvalid}, 32'd0);
                end else begin
                    exp_t e;
                    e = rq.pop_front();
                    check("rdata", {24'd0, hs_rdata}, {24'd0, e.data});
                    check("rvalid_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        // Reset state
        tick(2);
        check("rst_grant", {31'd0, hs_grant}, 32'd0);
        check("rst_rdata", {24'd0, hs_rdata}, 32'd0);
        check("rst_rvalid", {31'd0, hs_rvalid}, 32'd0);
        check("rst_timeout", {31'd0, hs_timeout}, 32'd0);
        check("rst_pause_req", {31'd0, pause_req}, 32'd0);
        check("rst_ram_addr", {20'd0, ram_addr}, 32'd0);
        check("rst_ram_wdata", {24'd0, ram_wdata}, 32'd0);
        check("rst_ram_we", {31'd0, ram_we}, 32'd0);
        reset_n = 1'b1;
        tick(2);

        // Basic session: hs_req at cycle 0, cpu_paused at 5, grant at 10
        hs_req = 1'b1;
        tick();
        check("pause_req_rise", {31'd0, pause_req}, 32'd1);
        check("grant_while_pausing", {31'd0, hs_grant}, 32'd0);
        tick();
        hs_we = 1'b1; hs_rd = 1'b1; hs_addr = 12'h3FF; hs_wdata = 8'hEE;
        tick();
        hs_we = 1'b0; hs_rd = 1'b0;
        tick();
        check("ungranted_addr_hold", {20'd0, ram_addr}, 32'd0);
        tick();
        cpu_paused = 1'b1;
        tick(4);
        check("grant_before_settle", {31'd0, hs_grant}, 32'd0);
        tick();
        check("grant_after_settle", {31'd0, hs_grant}, 32'd1);

        // Single write, then write+read together (write only)
        hs_we = 1'b1; hs_addr = 12'h123; hs_wdata = 8'h5A;
        push_write(12'h123, 8'h5A);
        tick();
        hs_we = 1'b0;
        tick();
        hs_we = 1'b1; hs_rd = 1'b1; hs_addr = 12'h200; hs_wdata = 8'hC3;
        push_write(12'h200, 8'hC3);
        tick();
        hs_we = 1'b0; hs_rd = 1'b0;

        // Three back-to-back reads
        for (int i = 0; i < 3; i++) begin
            hs_rd = 1'b1; hs_addr = AW'(12'h010 + i);
            push_read(hs_addr);
            tick();
        end
        hs_rd = 1'b0;
        tick(5);
        check("ram_addr_hold", {20'd0, ram_addr}, 32'h012);
        check("ram_wdata_hold", {24'd0, ram_wdata}, 32'hC3);

        // Pause lost with a read in flight
        hs_rd = 1'b1; hs_addr = 12'h034;
        push_read(hs_addr);
        tick();
        hs_rd = 1'b0; cpu_paused = 1'b0;
        check("grant_before_loss", {31'd0, hs_grant}, 32'd1);
        tick();
        check("grant_dropped", {31'd0, hs_grant}, 32'd0);
        check("pause_held_on_loss", {31'd0, pause_req}, 32'd1);
        cpu_paused = 1'b1; hs_rd = 1'b1; hs_addr = 12'h077;
        tick();
        hs_rd = 1'b0;
        tick(3);
        check("regrant_early", {31'd0, hs_grant}, 32'd0);
        tick();
        check("regrant", {31'd0, hs_grant}, 32'd1);

        // Release, with hs_req re-asserted during RELEASE
        hs_req = 1'b0;
        tick();
        check("rel_grant_fall", {31'd0, hs_grant}, 32'd0);
        check("rel_pause_1", {31'd0, pause_req}, 32'd1);
        hs_req = 1'b1;
        tick();
        check("rel_pause_2", {31'd0, pause_req}, 32'd1);
        tick();
        check("rel_pause_fall", {31'd0, pause_req}, 32'd0);
        tick();
        check("rereq_pause", {31'd0, pause_req}, 32'd1);
        tick(4);
        check("rereq_grant_early", {31'd0, hs_grant}, 32'd0);
        tick();
        check("rereq_grant", {31'd0, hs_grant}, 32'd1);

        // Asynchronous reset mid-GRANTED
        check("pre_rst_rdata", {24'd0, hs_rdata}, 32'h34);
        reset_n = 1'b0;
        #1;
        check("arst_grant", {31'd0, hs_grant}, 32'd0);
        check("arst_pause_req", {31'd0, pause_req}, 32'd0);
        check("arst_rdata", {24'd0, hs_rdata}, 32'd0);
        check("arst_ram_addr", {20'd0, ram_addr}, 32'd0);
        check("arst_ram_wdata", {24'd0, ram_wdata}, 32'd0);
        hs_req = 1'b0; cpu_paused = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(2);

`ifdef HSARB_TIMEOUT_EN
        // Timeout after 16 PAUSING cycles with cpu_paused held low
        hs_req = 1'b1;
        tick(16);
        check("tmo_not_yet", {31'd0, hs_timeout}, 32'd0);
        tick();
        check("tmo_set", {31'd0, hs_timeout}, 32'd1);
        check("tmo_release_pause", {31'd0, pause_req}, 32'd1);
        tick(2);
        check("tmo_idle_pause", {31'd0, pause_req}, 32'd0);
        tick(5);
        check("tmo_no_retry", {31'd0, pause_req}, 32'd0);
        check("tmo_sticky", {31'd0, hs_timeout}, 32'd1);
        hs_req = 1'b0;
        tick(2);
        hs_req = 1'b1;
        tick();
        check("tmo_retry_pause", {31'd0, pause_req}, 32'd1);
        check("tmo_sticky_retry", {31'd0, hs_timeout}, 32'd1);
        hs_req = 1'b0;
        tick(4);
`else
        // Without the timeout build, PAUSING waits indefinitely
        hs_req = 1'b1;
        tick(40);
        check("no_tmo_pause", {31'd0, pause_req}, 32'd1);
        check("no_tmo_flag", {31'd0, hs_timeout}, 32'd0);
        hs_req = 1'b0;
        tick(4);
`endif

        check("write_queue_drained", wq.size(), 32'd0);
        check("read_queue_drained", rq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
